// File: rtl/axi_mm_ram_responder_if.sv
// if_axi_mm: single-word memory-mapped request/response bus.
//   source drives addr, wr_dat, wr, rd; sink drives rd_dat, rd_dat_val, wait_rq.
//   The source must hold its request while wait_rq is high.
interface if_axi_mm #(
  parameter int unsigned D_BITS = 64,
  parameter int unsigned A_BITS = 8
);
  logic [A_BITS-1:0] addr;
  logic [D_BITS-1:0] wr_dat;
  logic              wr;
  logic              rd;
  logic [D_BITS-1:0] rd_dat;
  logic              rd_dat_val;
  logic              wait_rq;

  modport source (
    output addr, wr_dat, wr, rd,
    input  rd_dat, rd_dat_val, wait_rq
  );

  modport sink (
    input  addr, wr_dat, wr, rd,
    output rd_dat, rd_dat_val, wait_rq
  );
endinterface

// File: rtl/axi_mm_ram_responder.sv
// axi_mm_ram_responder: sink end of if_axi_mm backed by an on-chip RAM.
//   Writes complete in the accept cycle with no stall. Each accepted read
//   holds wait_rq high until its data returns RD_LAT cycles after accept.
// Ports:
//   i_clk      clock
//   i_rst      asynchronous active-high reset
//   i_axi      if_axi_mm sink (addr, wr_dat, wr, rd in; rd_dat, rd_dat_val, wait_rq out)
//   o_addr_err sticky flag: some access used addr >= WORDS; cleared only by reset
module axi_mm_ram_responder #(
  parameter int unsigned D_BITS = 64,
  parameter int unsigned A_BITS = 8,
  parameter int unsigned WORDS  = 2**A_BITS,
  parameter int unsigned RD_LAT = 2
) (
  input  logic   i_clk,
  input  logic   i_rst,
  if_axi_mm.sink i_axi,
  output logic   o_addr_err
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam bit          LAT1  = (RD_LAT == 1);

  typedef enum logic {IDLE, RD_PEND} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [D_BITS-1:0] mem [WORDS];
  logic [D_BITS-1:0] rd_buf;
  logic [D_BITS-1:0] rd_dat;
  logic              rd_dat_val;
  logic              lat1_pend;
  logic              accept;
  logic              accept_rd;
  logic              in_range;
  logic              fire;
  logic [IDX_W-1:0]  idx;

  // Range test on the full address; the low index bits alone would alias.
  assign in_range  = (64'(i_axi.addr) < 64'(WORDS));
  assign idx       = i_axi.addr[IDX_W-1:0];
  assign accept    = (state == IDLE) && (i_axi.rd || i_axi.wr);
  assign accept_rd = accept && i_axi.rd;

  // RD_LAT==1 never leaves IDLE; a one-cycle flag stands in for the counter.
  assign fire = LAT1 ? lat1_pend : ((state == RD_PEND) && (cnt == '0));

  assign i_axi.wait_rq    = (state != IDLE);
  assign i_axi.rd_dat     = rd_dat;
  assign i_axi.rd_dat_val = rd_dat_val;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept_rd && !LAT1) begin
          state_nx = RD_PEND;
          cnt_nx   = CNT_W'(RD_LAT - 1);
        end
      end
      RD_PEND: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat1_pend  <= 1'b0;
      rd_buf     <= '0;
      rd_dat     <= '0;
      rd_dat_val <= 1'b0;
      o_addr_err <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      lat1_pend  <= LAT1 && accept_rd;
      rd_dat_val <= fire;
      if (fire) rd_dat <= rd_buf;
      // Read-first: a write accepted on the same edge is not visible here.
      if (accept_rd) rd_buf <= in_range ? mem[idx] : '0;
      if (accept && !in_range) o_addr_err <= 1'b1;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && accept && i_axi.wr && in_range) mem[idx] <= i_axi.wr_dat;
  end

endmodule

// File: tb/tb_axi_mm_ram_responder.sv
// Directed bench for axi_mm_ram_responder. Three instances share clock and
// reset: k=0 (WORDS=100, RD_LAT=2), k=1 (RD_LAT=1), k=2 (RD_LAT=4).
module tb_axi_mm_ram_responder;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr [NDUT];
  logic [63:0] wdat [NDUT];
  logic        wr   [NDUT];
  logic        rd   [NDUT];
  logic [63:0] rdat [NDUT];
  logic        rval [NDUT];
  logic        wrq  [NDUT];
  logic        err  [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g
    localparam int unsigned LAT = (k == 0) ? 2 : (k == 1) ? 1 : 4;
    localparam int unsigned WDS = (k == 0) ? 100 : 256;
    if_axi_mm #(.D_BITS(64), .A_BITS(8)) bus ();
    assign bus.addr   = addr[k];
    assign bus.wr_dat = wdat[k];
    assign bus.wr     = wr[k];
    assign bus.rd     = rd[k];
    assign rdat[k]    = bus.rd_dat;
    assign rval[k]    = bus.rd_dat_val;
    assign wrq[k]     = bus.wait_rq;
    axi_mm_ram_responder #(.D_BITS(64), .A_BITS(8), .WORDS(WDS), .RD_LAT(LAT)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_axi      (bus.sink),
      .o_addr_err (err[k])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_word(input int k, input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    addr[k] = a; wdat[k] = d; wr[k] = 1'b1; rd[k] = 1'b0;
    @(posedge clk); #1;
    wr[k] = 1'b0;
  endtask

  // Issues one read (optionally with a simultaneous write), then waits up to
  // 20 cycles for the return. hi counts cycles with wait_rq high before it.
  task automatic rd_word(input int k, input logic [7:0] a, input bit with_wr,
                         input logic [63:0] wd, output logic [63:0] d,
                         output int lat, output int hi, output logic wq_ret);
    @(negedge clk);
    addr[k] = a; rd[k] = 1'b1; wr[k] = with_wr; wdat[k] = wd;
    @(posedge clk); #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
    d = '0; lat = -1; hi = 0; wq_ret = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      if (rval[k]) begin
        lat = n; d = rdat[k]; wq_ret = wrq[k];
        break;
      end
      if (wrq[k]) hi++;
      @(posedge clk); #1;
    end
  endtask

  task automatic rd_chk(input int k, input logic [7:0] a, input bit with_wr,
                        input logic [63:0] wd, input logic [63:0] exp, input string tag);
    logic [63:0] d;
    int          lat, hi;
    logic        wq_ret;
    rd_word(k, a, with_wr, wd, d, lat, hi, wq_ret);
    check({tag, "_data"}, d, exp);
    check({tag, "_lat"}, 64'(lat), 64'(lat_of(k)));
    check({tag, "_wrq_hi"}, 64'(hi), 64'((lat_of(k) > 1) ? lat_of(k) : 0));
    check({tag, "_wrq_ret"}, 64'(wq_ret), 64'(0));
  endtask

  initial begin
    int rets, gap_bad, dat_bad, last, wq_bad, seen;
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      addr[k] = '0; wdat[k] = '0; wr[k] = 1'b0; rd[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_rdat%0d", k), rdat[k], 64'(0));
      check($sformatf("rst_rval%0d", k), 64'(rval[k]), 64'(0));
      check($sformatf("rst_wrq%0d", k), 64'(wrq[k]), 64'(0));
      check($sformatf("rst_err%0d", k), 64'(err[k]), 64'(0));
    end
    rst = 1'b0;

    // Basic write then read.
    wr_word(0, 8'h05, 64'hDEAD_BEEF_0000_0001);
    rd_chk(0, 8'h05, 1'b0, '0, 64'hDEAD_BEEF_0000_0001, "basic");
    @(posedge clk); #1;
    check("basic_pulse_1cyc", 64'(rval[0]), 64'(0));

    // 16 back-to-back writes, then read them all back.
    wq_bad = 0;
    for (int i = 0; i < 16; i++) begin
      wr_word(0, 8'(i), 64'(i * 3));
      if (wrq[0]) wq_bad++;
    end
    check("b2b_wr_wrq", 64'(wq_bad), 64'(0));
    for (int i = 0; i < 16; i++)
      rd_chk(0, 8'(i), 1'b0, '0, 64'(i * 3), $sformatf("rd16_%0d", i));

    // rd held on addr 2 for 20 cycles; stray wr/addr while stalled must be ignored.
    rets = 0; gap_bad = 0; dat_bad = 0; last = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      rd[0] = 1'b1;
      if (wrq[0]) begin addr[0] = 8'h03; wr[0] = 1'b1; wdat[0] = 64'hBAD; end
      else begin addr[0] = 8'h02; wr[0] = 1'b0; end
      @(posedge clk); #1;
      if (rval[0]) begin
        rets++;
        if (rdat[0] !== 64'd6) dat_bad++;
        if (last >= 0 && j - last != 3) gap_bad++;
        last = j;
      end
    end
    @(negedge clk); rd[0] = 1'b0; wr[0] = 1'b0;
    repeat (4) @(posedge clk);
    check("hold_returns", 64'(rets), 64'(6));
    check("hold_gap", 64'(gap_bad), 64'(0));
    check("hold_data", 64'(dat_bad), 64'(0));
    rd_chk(0, 8'h03, 1'b0, '0, 64'd9, "hold_no_stray_wr");

    // Simultaneous rd & wr: read-first.
    wr_word(0, 8'h07, 64'h11);
    rd_chk(0, 8'h07, 1'b1, 64'h22, 64'h11, "rdwr_old");
    rd_chk(0, 8'h07, 1'b0, '0, 64'h22, "rdwr_new");

    // Out of range with WORDS=100: 0xC8 must not alias onto 0x48.
    wr_word(0, 8'h48, 64'h1234);
    check("oor_err_before", 64'(err[0]), 64'(0));
    wr_word(0, 8'hC8, 64'hFF);
    check("oor_err_set", 64'(err[0]), 64'(1));
    rd_chk(0, 8'hC8, 1'b0, '0, 64'h0, "oor_rd");
    rd_chk(0, 8'h48, 1'b0, '0, 64'h1234, "oor_alias");
    check("oor_err_sticky", 64'(err[0]), 64'(1));

    // Prepare k=1,2 with data and a nonzero rd_dat.
    for (int k = 0; k < NDUT; k++) wr_word(k, 8'h09, 64'hA5A5_0000_0000_0009 + 64'(k));
    for (int k = 1; k < NDUT; k++)
      rd_chk(k, 8'h09, 1'b0, '0, 64'hA5A5_0000_0000_0009 + 64'(k), $sformatf("lat%0d", k));

    // Reset while reads are pending on all three instances.
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin addr[k] = 8'h09; rd[k] = 1'b1; end
    @(posedge clk); #1;
    for (int k = 0; k < NDUT; k++) rd[k] = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("midrst_rdat%0d", k), rdat[k], 64'(0));
      check($sformatf("midrst_rval%0d", k), 64'(rval[k]), 64'(0));
      check($sformatf("midrst_wrq%0d", k), 64'(wrq[k]), 64'(0));
      check($sformatf("midrst_err%0d", k), 64'(err[k]), 64'(0));
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) if (rval[k]) seen++;
    end
    check("midrst_no_ret", 64'(seen), 64'(0));
    for (int k = 0; k < NDUT; k++)
      rd_chk(k, 8'h09, 1'b0, '0, 64'hA5A5_0000_0000_0009 + 64'(k), $sformatf("after_rst%0d", k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
